// File: rtl/puf_response_collector_pkg.sv
// Shared types and constants for the PDL arbiter PUF response collector.
//   state_e        : collector FSM states
//   PUF_DATA_WIDTH : arbiter bank width, shared with the arbiter flop bank
//   cnt_width()    : width of a counter that must hold 0..n inclusive
package puf_response_collector_pkg;

  localparam int PUF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    SAMPLE,
    RELAX,
    DONE
  } state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_response_collector_if.sv
// Collector bus: challenge trigger, race launch, arbiter sample inputs and
// the voted response handshake.
//   slave  : collector side (drives launch/busy/resp/unstable/resp_valid)
//   master : requester / arbiter bank / reply path side
interface puf_response_collector_if
  import puf_response_collector_pkg::*;
#(
  parameter int DATA_WIDTH = PUF_DATA_WIDTH
);
  logic                  start;
  logic                  launch;
  logic [DATA_WIDTH-1:0] arb_q;
  logic                  busy;
  logic [DATA_WIDTH-1:0] resp;
  logic [DATA_WIDTH-1:0] unstable;
  logic                  resp_valid;
  logic                  resp_ready;

  modport slave (
    input  start, arb_q, resp_ready,
    output launch, busy, resp, unstable, resp_valid
  );

  modport master (
    output start, arb_q, resp_ready,
    input  launch, busy, resp, unstable, resp_valid
  );
endinterface

// File: rtl/puf_response_collector_vote_cell.sv
// One arbiter lane: 2-flop synchroniser, evaluation counter and vote.
//   clk/rst  : clock, synchronous active-high reset
//   clr      : zero the counter (start of a collection)
//   inc_en   : add the synchronised bit to the counter this cycle
//   num_eval : evaluations per collection
//   arb_q    : raw arbiter output, asynchronous to clk
//   resp     : majority vote, ties resolve to 0
//   unstable : lane disagreed with itself across evaluations
module puf_vote_cell #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [CW-1:0] num_eval,
  input  logic          arb_q,
  output logic          resp,
  output logic          unstable
);
  logic          s1, s2;
  logic [CW-1:0] cnt;

  // inc_en fires once per evaluation, so cnt never exceeds num_eval.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= arb_q;
      s2 <= s1;
      if (clr)         cnt <= '0;
      else if (inc_en) cnt <= cnt + CW'(s2);
    end
  end

  assign resp     = cnt > (num_eval >> 1);
  assign unstable = (cnt != '0) && (cnt != num_eval);
endmodule

// File: rtl/puf_response_collector.sv
// Arbiter PUF response collector. Launches NUM_EVAL races, samples the
// synchronised arbiter bank after each settle window, and presents a
// per-bit majority response with an instability mask.
//   clk/rst : clock, synchronous active-high reset
//   bus     : collector interface (slave modport)
module puf_response_collector
  import puf_response_collector_pkg::*;
#(
  parameter int DATA_WIDTH = PUF_DATA_WIDTH,
  parameter int NUM_EVAL   = 7,
  parameter int SETTLE_CYC = 8,
  parameter int RELAX_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  puf_response_collector_if.slave  bus
);
  localparam int CW   = cnt_width(NUM_EVAL);
  localparam int TMAX = (SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] NE       = CW'(NUM_EVAL);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] REL_LAST = TW'(RELAX_CYC - 1);

  state_e                state, state_nxt;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         eval_cnt;
  logic                  launch_q;
  logic [DATA_WIDTH-1:0] resp_q, unst_q;
  logic [DATA_WIDTH-1:0] vote_resp, vote_unst;
  logic                  clr, inc_en;

  assign clr    = (state == IDLE) && bus.start;
  assign inc_en = (state == SAMPLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = FIRE;
      FIRE:    if (timer == SET_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = RELAX;
      RELAX:   if (timer == REL_LAST) state_nxt = (eval_cnt < NE) ? FIRE : DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      eval_cnt <= '0;
      launch_q <= 1'b0;
      resp_q   <= '0;
      unst_q   <= '0;
    end else begin
      state <= state_nxt;
      // timer counts cycles spent in the current state
      timer <= (state_nxt != state) ? '0 : timer + TW'(1);
      if (clr)         eval_cnt <= '0;
      else if (inc_en) eval_cnt <= eval_cnt + CW'(1);
      // launch registered from next state so the race edge is glitch-free
      // and only falls on the SAMPLE->RELAX transition
      launch_q <= (state_nxt == FIRE) || (state_nxt == SAMPLE);
      if (state == RELAX && state_nxt == DONE) begin
        resp_q <= vote_resp;
        unst_q <= vote_unst;
      end
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    puf_vote_cell #(.CW(CW)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .inc_en   (inc_en),
      .num_eval (NE),
      .arb_q    (bus.arb_q[i]),
      .resp     (vote_resp[i]),
      .unstable (vote_unst[i])
    );
  end

  assign bus.launch     = launch_q;
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp       = resp_q;
  assign bus.unstable   = unst_q;
endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;
  import puf_response_collector_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_response_collector_if #(.DATA_WIDTH(32)) ifa ();
  puf_response_collector_if #(.DATA_WIDTH(32)) ifb ();

  puf_response_collector #(.DATA_WIDTH(32), .NUM_EVAL(7), .SETTLE_CYC(8), .RELAX_CYC(8))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  puf_response_collector #(.DATA_WIDTH(32), .NUM_EVAL(4), .SETTLE_CYC(8), .RELAX_CYC(8))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 7-eval collection on dut_a. pats[e] is presented for evaluation e.
  // inj = eval index during whose FIRE a stray start pulse is applied (-1: none).
  task automatic collect(input logic [31:0] pats [7], input int inj);
    ifa.start = 1'b1;
    for (int e = 0; e < 7; e++) begin
      ifa.arb_q = pats[e];
      for (int j = 1; j <= 17; j++) begin
        tick();
        ifa.start = (e == inj) && (j == 3);
        if (j == 9) begin
          checks++;
          if (ifa.launch !== 1'b1) begin
            failures++;
            $display("FAIL launch_sample eval=%0d got=%b want=1", e, ifa.launch);
          end
        end
        if (j == 10) begin
          checks++;
          if (ifa.launch !== 1'b0) begin
            failures++;
            $display("FAIL launch_relax eval=%0d got=%b want=0", e, ifa.launch);
          end
        end
      end
    end
    checks++;
    if (ifa.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL resp_valid_early cycle=119 got=%b want=0", ifa.resp_valid);
    end
    tick();
    checks++;
    if (ifa.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL resp_valid_latency cycle=120 got=%b want=1", ifa.resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 0; ifa.arb_q = '0; ifa.resp_ready = 0;
    ifb.start = 0; ifb.arb_q = '0; ifb.resp_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({ifa.launch, ifa.busy, ifa.resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got launch/busy/valid=%b want=000",
               {ifa.launch, ifa.busy, ifa.resp_valid});
    end
    checks++;
    if (ifa.resp !== 32'h0 || ifa.unstable !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got resp=%h unstable=%h want 0/0", ifa.resp, ifa.unstable);
    end
  endtask

  task automatic test_constant();
    logic [31:0] p [7];
    for (int i = 0; i < 7; i++) p[i] = 32'hA5A5_F00F;
    collect(p, -1);
    checks++;
    if (ifa.resp !== 32'hA5A5_F00F) begin
      failures++;
      $display("FAIL const_resp got=%h want=a5a5f00f", ifa.resp);
    end
    checks++;
    if (ifa.unstable !== 32'h0) begin
      failures++;
      $display("FAIL const_unstable got=%h want=0", ifa.unstable);
    end
  endtask

  task automatic test_hold_ready();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (ifa.resp_valid !== 1'b1 || ifa.resp !== 32'hA5A5_F00F || ifa.launch !== 1'b0) begin
        failures++;
        $display("FAIL hold_done cyc=%0d got valid=%b resp=%h launch=%b want 1/a5a5f00f/0",
                 c, ifa.resp_valid, ifa.resp, ifa.launch);
      end
    end
    ifa.resp_ready = 1'b1;
    tick();
    ifa.resp_ready = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got busy=%b valid=%b want 0/0", ifa.busy, ifa.resp_valid);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] p [7];
    p = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1};
    collect(p, -1);
    checks++;
    if (ifa.resp !== 32'h1 || ifa.unstable !== 32'h1) begin
      failures++;
      $display("FAIL toggle_vote got resp=%h unstable=%h want 1/1", ifa.resp, ifa.unstable);
    end
    ifa.resp_ready = 1'b1;
    tick();
    ifa.resp_ready = 1'b0;
  endtask

  // NUM_EVAL=4: bit5 high 2/4 (tie), bit7 high 3/4, bit9 high 4/4.
  task automatic test_tie();
    logic [31:0] p [4];
    p = '{32'h2A0, 32'h2A0, 32'h280, 32'h200};
    ifb.start = 1'b1;
    for (int e = 0; e < 4; e++) begin
      ifb.arb_q = p[e];
      for (int j = 0; j < 17; j++) begin
        tick();
        ifb.start = 1'b0;
      end
    end
    checks++;
    if (ifb.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL tie_early cycle=68 got=%b want=0", ifb.resp_valid);
    end
    tick();
    checks++;
    if (ifb.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL tie_latency cycle=69 got=%b want=1", ifb.resp_valid);
    end
    checks++;
    if (ifb.resp !== 32'h280 || ifb.unstable !== 32'h0A0) begin
      failures++;
      $display("FAIL tie_vote got resp=%h unstable=%h want 280/0a0", ifb.resp, ifb.unstable);
    end
    ifb.resp_ready = 1'b1;
    tick();
    ifb.resp_ready = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [31:0] p [7];
    int extra;
    for (int i = 0; i < 7; i++) p[i] = 32'h0000_FFFF;
    collect(p, 2);
    checks++;
    if (ifa.resp !== 32'h0000_FFFF || ifa.unstable !== 32'h0) begin
      failures++;
      $display("FAIL ignore_vote got resp=%h unstable=%h want 0000ffff/0", ifa.resp, ifa.unstable);
    end
    ifa.resp_ready = 1'b1;
    ifa.start      = 1'b1;
    tick();
    ifa.resp_ready = 1'b0;
    ifa.start      = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_handshake got busy=%b want=0", ifa.busy);
    end
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (ifa.busy !== 1'b0 || ifa.resp_valid !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_no_second got active_cycles=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p [7];
    ifa.start = 1'b1;
    ifa.arb_q = 32'h1234_5678;
    tick();
    ifa.start = 1'b0;
    repeat (25) tick();  // now in SAMPLE of the second evaluation
    checks++;
    if (ifa.launch !== 1'b1 || ifa.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrace_pre got launch=%b busy=%b want 1/1", ifa.launch, ifa.busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ifa.launch, ifa.busy, ifa.resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midrace_reset got launch/busy/valid=%b want=000",
               {ifa.launch, ifa.busy, ifa.resp_valid});
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) p[i] = 32'h0F0F_0F0F;
    collect(p, -1);
    checks++;
    if (ifa.resp !== 32'h0F0F_0F0F || ifa.unstable !== 32'h0) begin
      failures++;
      $display("FAIL midrace_fresh got resp=%h unstable=%h want 0f0f0f0f/0", ifa.resp, ifa.unstable);
    end
    ifa.resp_ready = 1'b1;
    tick();
    ifa.resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_hold_ready();
    test_toggle();
    test_tie();
    test_ignore_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
